// File: rtl/arb3_mux_pkg.sv
// Shared constants, control state encoding and mod-3 pointer helper
// for the three-way round-robin arbiter.
package arb3_mux_pkg;

    localparam int SRC_W = 2;

    localparam logic [SRC_W-1:0] SRC0       = 2'd0;
    localparam logic [SRC_W-1:0] SRC1       = 2'd1;
    localparam logic [SRC_W-1:0] SRC2       = 2'd2;
    localparam logic [SRC_W-1:0] LAST_RESET = 2'd2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Wraps 2 -> 0; the unused code 3 also folds to 0 so it can never propagate.
    function automatic logic [SRC_W-1:0] inc_mod3(input logic [SRC_W-1:0] v);
        logic [SRC_W-1:0] r;
        case (v)
            SRC0:    r = SRC1;
            SRC1:    r = SRC2;
            default: r = SRC0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arb3_mux_muxb3.sv
// Three-input binary-select mux: sb selects d0/d1/d2; the unused code 3 yields zero.
module Muxb3 #(
    parameter int K = 4
) (
    input  logic [K-1:0] d2,
    input  logic [K-1:0] d1,
    input  logic [K-1:0] d0,
    input  logic [1:0]   sb,
    output logic [K-1:0] y
);

    always_comb begin
        y = '0;
        case (sb)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/arb3_mux.sv
// Round-robin arbiter over three requesters feeding one registered
// valid/ready output slot through the shared Muxb3 data path.
module arb3_mux
    import arb3_mux_pkg::*;
#(
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [K-1:0]     d0,
    input  logic [K-1:0]     d1,
    input  logic [K-1:0]     d2,
    output logic [2:0]       ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     out_data,
    output logic [SRC_W-1:0] out_src
);

    slot_state_t      state, state_next;
    logic [SRC_W-1:0] last;
    logic [SRC_W-1:0] cand1, cand2;
    logic [SRC_W-1:0] win;
    logic [SRC_W-1:0] sb;
    logic             any_req;
    logic             free;
    logic             cap;
    logic [K-1:0]     mux_y;

    assign out_valid = (state == FULL);
    assign any_req   = |req;
    assign free      = !out_valid || out_ready;
    assign cap       = free && any_req && !reset;

    // Search order last+1, last+2, last: the most recent winner is tried last.
    always_comb begin
        cand1 = inc_mod3(last);
        cand2 = inc_mod3(cand1);
        if (req[cand1])
            win = cand1;
        else if (req[cand2])
            win = cand2;
        else
            win = last;
    end

    assign sb = cap ? win : SRC0;

    Muxb3 #(.K(K)) u_mux (
        .d2 (d2),
        .d1 (d1),
        .d0 (d0),
        .sb (sb),
        .y  (mux_y)
    );

    // Control state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_next;
    end

    // Next-state logic: a full slot only changes when the consumer drains it
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   state_next = cap ? FULL : EMPTY;
            FULL: begin
                if (out_ready)
                    state_next = any_req ? FULL : EMPTY;
                else
                    state_next = FULL;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Output logic: grant is combinational and one-hot on the captured requester
    always_comb begin
        ack = 3'b000;
        if (cap)
            ack = 3'b001 << sb;
    end

    // Slot data, source tag and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_src  <= SRC0;
            last     <= LAST_RESET;
        end else if (cap) begin
            out_data <= mux_y;
            out_src  <= sb;
            last     <= sb;
        end
    end

endmodule
